// File: rtl/inet_checksum_stream.sv
// Streaming RFC 1071 ones'-complement checksum engine.
// Accepts DATA_BYTES bytes per beat with contiguous byte qualifiers and
// realigns bytes by their running stream offset, so frames may split
// 16-bit words across beats. A frame's result appears exactly four cycles
// after its end_of_frame beat. Each frame is seeded with initial_sum on its
// first beat, so back-to-back frames do not disturb each other.
//
// Handshake: data_valid qualifies a beat. The block is always ready, so
// every beat with data_valid high is consumed at the clock edge where it is
// sampled. There is no back-pressure.
module inet_checksum_stream #(
  parameter int DATA_BYTES   = 2,
  parameter int UDP_ZERO_MAP = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    data_valid,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   data_keep,
  input  logic                    end_of_frame,
  input  logic [15:0]             initial_sum,
  input  logic [15:0]             checksum_expected,
  output logic                    checksum_done,
  output logic                    checksum_correct,
  output logic [15:0]             checksum_value,
  output logic                    frame_active,
  output logic [0:0]              fsm_state
);

  // Number of 16-bit words needed to hold one beat shifted by one byte.
  localparam int AW   = DATA_BYTES / 2 + 1;
  localparam int EW   = 16 * AW;
  localparam int PADW = EW - 8 * DATA_BYTES;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [1:0] rst_sync;
  logic       rst_n_int;

  logic [0:0] state;
  logic       par;
  logic       start;
  logic       par_base;
  logic       keep_par;

  logic [8*DATA_BYTES-1:0] masked;
  logic [EW-1:0]           extended;
  logic [EW-1:0]           aligned;

  logic          s1_valid, s1_first, s1_eof;
  logic [15:0]   s1_seed, s1_exp;
  logic [EW-1:0] s1_bytes;

  logic [18:0]   word_sum;
  logic          s2_valid, s2_first, s2_eof;
  logic [15:0]   s2_seed, s2_exp;
  logic [18:0]   s2_sum;

  logic [15:0]   base;
  logic [19:0]   total;
  logic [16:0]   fold1;
  logic [15:0]   fold2;
  logic [15:0]   acc;
  logic          s3_eof;
  logic [15:0]   s3_exp;

  logic [15:0]   inv;
  logic [15:0]   mapped;
  logic          s4_done;
  logic [15:0]   s4_value;
  logic          s4_match;

  // Reset asserts immediately and releases two clock edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  // A beat in IDLE starts a frame; its byte offset restarts at zero.
  assign start    = data_valid && (state == S_IDLE);
  assign par_base = start ? 1'b0 : par;
  assign keep_par = ^data_keep;

  assign frame_active = rst_n_int && ((state == S_ACCUM) || data_valid);
  assign fsm_state    = state;

  // Frame state and the parity of the next byte's stream offset.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= S_IDLE;
      par   <= 1'b0;
    end else if (data_valid) begin
      par   <= par_base ^ keep_par;
      state <= end_of_frame ? S_IDLE : S_ACCUM;
    end
  end

  // Zero unqualified bytes so they contribute nothing to the sum.
  always_comb begin
    masked = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (data_keep[i]) masked[8*(DATA_BYTES-1-i) +: 8] = data[8*(DATA_BYTES-1-i) +: 8];
    end
  end

  // An odd starting offset pushes byte 0 into the low half of the first word.
  assign extended = {masked, {PADW{1'b0}}};
  assign aligned  = par_base ? (extended >> 8) : extended;

  // Stage 1: aligned bytes plus the frame bookkeeping carried along with them.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_eof   <= 1'b0;
      s1_seed  <= 16'h0000;
      s1_exp   <= 16'h0000;
      s1_bytes <= '0;
    end else begin
      s1_valid <= data_valid;
      s1_first <= start;
      s1_eof   <= data_valid && end_of_frame;
      if (data_valid) begin
        s1_bytes <= aligned;
        s1_seed  <= initial_sum;
        s1_exp   <= checksum_expected;
      end
    end
  end

  // Plain binary sum of the beat's aligned 16-bit words.
  always_comb begin
    word_sum = '0;
    for (int w = 0; w < AW; w++) begin
      word_sum = word_sum + 19'(s1_bytes[EW-1-16*w -: 16]);
    end
  end

  // Stage 2: registered beat word sum.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_eof   <= 1'b0;
      s2_seed  <= 16'h0000;
      s2_exp   <= 16'h0000;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_eof   <= s1_eof;
      s2_seed  <= s1_seed;
      s2_exp   <= s1_exp;
      s2_sum   <= word_sum;
    end
  end

  // End-around carry: two folds always bring the total back into 16 bits.
  assign base  = s2_first ? s2_seed : acc;
  assign total = {4'b0000, base} + {1'b0, s2_sum};
  assign fold1 = {1'b0, total[15:0]} + {13'b0, total[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  // Stage 3: ones'-complement accumulator, restarted from the seed per frame.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      acc    <= 16'h0000;
      s3_eof <= 1'b0;
      s3_exp <= 16'h0000;
    end else begin
      if (s2_valid) acc <= fold2;
      s3_eof <= s2_valid && s2_eof;
      if (s2_valid && s2_eof) s3_exp <= s2_exp;
    end
  end

  assign inv    = ~acc;
  assign mapped = ((UDP_ZERO_MAP != 0) && (inv == 16'h0000)) ? 16'hFFFF : inv;

  // Stage 4: final inversion, optional zero mapping and comparison.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s4_done  <= 1'b0;
      s4_value <= 16'h0000;
      s4_match <= 1'b0;
    end else begin
      s4_done <= s3_eof;
      if (s3_eof) begin
        s4_value <= mapped;
        s4_match <= (mapped == s3_exp);
      end
    end
  end

  // Result registers: one-cycle done pulse, value and flag held until next done.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      checksum_done    <= 1'b0;
      checksum_value   <= 16'h0000;
      checksum_correct <= 1'b0;
    end else begin
      checksum_done <= s4_done;
      if (s4_done) begin
        checksum_value   <= s4_value;
        checksum_correct <= s4_match;
      end
    end
  end

endmodule

// File: tb/tb_inet_checksum_stream.sv
// Bench for inet_checksum_stream: one instance with 2-byte beats and no zero
// mapping, one with 4-byte beats and UDP zero mapping. Directed frames use
// known checksum values; random frames are scored against a whole-frame
// ones'-complement model.
module tb_inet_checksum_stream;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT A: DATA_BYTES=2, UDP_ZERO_MAP=0 ----------------
  logic        a_valid = 1'b0, a_eof = 1'b0;
  logic [15:0] a_data = '0;
  logic [1:0]  a_keep = '0;
  logic [15:0] a_seed = '0, a_exp = '0;
  logic        a_done, a_ok, a_active;
  logic [15:0] a_value;
  logic [0:0]  a_state;

  inet_checksum_stream #(.DATA_BYTES(2), .UDP_ZERO_MAP(0)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .data_valid(a_valid), .data(a_data),
    .data_keep(a_keep), .end_of_frame(a_eof), .initial_sum(a_seed),
    .checksum_expected(a_exp), .checksum_done(a_done), .checksum_correct(a_ok),
    .checksum_value(a_value), .frame_active(a_active), .fsm_state(a_state)
  );

  // ---------------- DUT B: DATA_BYTES=4, UDP_ZERO_MAP=1 ----------------
  logic        b_valid = 1'b0, b_eof = 1'b0;
  logic [31:0] b_data = '0;
  logic [3:0]  b_keep = '0;
  logic [15:0] b_seed = '0, b_exp = '0;
  logic        b_done, b_ok, b_active;
  logic [15:0] b_value;
  logic [0:0]  b_state;

  inet_checksum_stream #(.DATA_BYTES(4), .UDP_ZERO_MAP(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .data_valid(b_valid), .data(b_data),
    .data_keep(b_keep), .end_of_frame(b_eof), .initial_sum(b_seed),
    .checksum_expected(b_exp), .checksum_done(b_done), .checksum_correct(b_ok),
    .checksum_value(b_value), .frame_active(b_active), .fsm_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  // Entry: {expected done cycle[48:17], expected correct[16], expected value[15:0]}
  logic [48:0] exp_q_a[$];
  logic [48:0] exp_q_b[$];
  logic [48:0] ea, eb;
  logic [7:0]  fb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole-frame reference: sum of big-endian words (odd tail padded) plus
  // the seed, reduced modulo 0xFFFF with a nonzero total never becoming 0.
  function automatic logic [15:0] model(input logic [15:0] seed, input bit map);
    longint s;
    longint f;
    logic [7:0] lo;
    logic [15:0] v;
    s = longint'(seed);
    for (int i = 0; i < fb.size(); i += 2) begin
      lo = (i + 1 < fb.size()) ? fb[i+1] : 8'h00;
      s = s + longint'({fb[i], lo});
    end
    f = (s == 0) ? 0 : ((s - 1) % 65535) + 1;
    v = ~16'(f);
    if (map && v == 16'h0000) v = 16'hFFFF;
    return v;
  endfunction

  // Monitor both result ports away from the active edge.
  always @(negedge clock) begin
    if (a_done) begin
      if (exp_q_a.size() == 0) check("a_stale_done", 32'(a_done), 32'd0);
      else begin
        ea = exp_q_a.pop_front();
        check("a_value", 32'(a_value), 32'(ea[15:0]));
        check("a_correct", 32'(a_ok), 32'(ea[16]));
        check("a_latency", 32'(cyc), ea[48:17]);
      end
    end
    if (b_done) begin
      if (exp_q_b.size() == 0) check("b_stale_done", 32'(b_done), 32'd0);
      else begin
        eb = exp_q_b.pop_front();
        check("b_value", 32'(b_value), 32'(eb[15:0]));
        check("b_correct", 32'(b_ok), 32'(eb[16]));
        check("b_latency", 32'(cyc), eb[48:17]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one beat for one cycle; an end_of_frame beat books its result.
  task automatic drive_beat(input int sel, input logic [63:0] d, input logic [7:0] keep,
                            input logic eof, input logic [15:0] seed,
                            input logic [15:0] expv, input logic [15:0] want);
    if (sel == 0) begin
      a_valid = 1'b1; a_data = d[15:0]; a_keep = keep[1:0];
      a_eof = eof; a_seed = seed; a_exp = expv;
      if (eof) exp_q_a.push_back({32'(cyc + 5), (expv == want), want});
    end else begin
      b_valid = 1'b1; b_data = d[31:0]; b_keep = keep[3:0];
      b_eof = eof; b_seed = seed; b_exp = expv;
      if (eof) exp_q_b.push_back({32'(cyc + 5), (expv == want), want});
    end
    @(posedge clock);
    #1;
    a_valid = 1'b0; a_eof = 1'b0;
    b_valid = 1'b0; b_eof = 1'b0;
  endtask

  // Send the bytes in fb; fixed=1 fills each beat, otherwise beats carry a
  // random 0..DATA_BYTES bytes and random gaps are inserted inside the frame.
  task automatic send_frame(input int sel, input logic [15:0] seed, input logic [15:0] expv,
                            input logic [15:0] want, input int max_gap, input bit fixed);
    int db, idx, rem, chunk, g;
    logic eof, first;
    logic [63:0] d;
    logic [7:0] keep;
    db = (sel == 0) ? 2 : 4;
    idx = 0;
    first = 1'b1;
    eof = 1'b0;
    while (!eof) begin
      rem = fb.size() - idx;
      chunk = fixed ? db : $urandom_range(0, db);
      if (chunk >= rem) begin
        chunk = rem;
        eof = 1'b1;
      end
      d = {$urandom, $urandom};
      for (int j = 0; j < chunk; j++) d[8*(db-1-j) +: 8] = fb[idx+j];
      keep = 8'((9'd1 << chunk) - 9'd1);
      drive_beat(sel, d, keep, eof, first ? seed : 16'($urandom),
                 eof ? expv : 16'($urandom), want);
      idx += chunk;
      first = 1'b0;
      if (!eof && max_gap > 0) begin
        g = $urandom_range(0, max_gap);
        if (g > 0) begin
          check(sel == 0 ? "a_active_gap" : "b_active_gap",
                32'(sel == 0 ? a_active : b_active), 32'd1);
          idle(g);
        end
      end
    end
  endtask

  task automatic load_words(input logic [15:0] w[]);
    fb.delete();
    foreach (w[i]) begin
      fb.push_back(w[i][15:8]);
      fb.push_back(w[i][7:0]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_done"}, 32'(a_done), 32'd0);
    check({tag, "_a_correct"}, 32'(a_ok), 32'd0);
    check({tag, "_a_value"}, 32'(a_value), 32'd0);
    check({tag, "_a_active"}, 32'(a_active), 32'd0);
    check({tag, "_b_done"}, 32'(b_done), 32'd0);
    check({tag, "_b_value"}, 32'(b_value), 32'd0);
    check({tag, "_b_active"}, 32'(b_active), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] ipv4[] = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                          16'h0000, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
  logic [15:0] seed, want, expv;
  int n;

  initial begin
    // Reset state
    idle(3);
    @(negedge clock);
    check_outputs_zero("por");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(4);

    // IPv4 header, matching and non-matching expected value
    load_words(ipv4);
    send_frame(0, 16'h0000, 16'hB861, 16'hB861, 0, 1);
    idle(2);
    send_frame(0, 16'h0000, 16'hB862, 16'hB861, 0, 1);
    idle(2);

    // Odd-length frame: 01 02 03
    fb.delete(); fb.push_back(8'h01); fb.push_back(8'h02); fb.push_back(8'h03);
    send_frame(0, 16'h0000, 16'hFBFD, 16'hFBFD, 0, 1);
    idle(2);

    // Cross-beat realignment on 4-byte beats with an in-frame gap
    drive_beat(1, 64'h0000_0000_0102_03AA, 8'b0111, 1'b0, 16'h0000, 16'h0000, 16'hEFF3);
    check("b_active_gap3", 32'(b_active), 32'd1);
    idle(3);
    drive_beat(1, 64'h0000_0000_0405_0607, 8'b1111, 1'b1, 16'h5555, 16'hEFF3, 16'hEFF3);
    @(negedge clock);
    check("b_active_after_eof", 32'(b_active), 32'd0);
    idle(2);

    // Zero result: mapped on B, unmapped on A
    drive_beat(1, 64'h0000_0000_FFFF_1234, 8'b0011, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF);
    drive_beat(0, 64'h0000_0000_0000_FFFF, 8'b11, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    idle(2);

    // Empty frame yields the inverted seed
    drive_beat(0, 64'h0000_0000_0000_ABCD, 8'b00, 1'b1, 16'h1234, 16'hEDCB, 16'hEDCB);
    idle(2);

    // Seeded frame followed immediately by another frame
    drive_beat(0, 64'h1234, 8'b11, 1'b1, 16'hEDCB, 16'h0000, 16'h0000);
    drive_beat(0, 64'h0001, 8'b11, 1'b1, 16'h0000, 16'hFFFE, 16'hFFFE);
    drive_beat(1, 64'h1234_0000, 8'b0011, 1'b1, 16'hEDCB, 16'h0000, 16'hFFFF);
    drive_beat(1, 64'h0001_0000, 8'b0011, 1'b1, 16'h0000, 16'hFFFE, 16'hFFFE);
    drain();

    // Reset in the middle of a frame: no result, outputs cleared
    drive_beat(0, 64'h1111, 8'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    drive_beat(0, 64'h2222, 8'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    reset_n = 1'b0;
    @(negedge clock);
    check_outputs_zero("mid_rst");
    idle(3);
    reset_n = 1'b1;
    idle(4);
    load_words(ipv4);
    send_frame(0, 16'h0000, 16'hB861, 16'hB861, 0, 1);
    idle(2);

    // Randomized frames on both instances
    for (int f = 0; f < 40; f++) begin
      fb.delete();
      n = $urandom_range(0, 20);
      repeat (n) fb.push_back(8'($urandom));
      seed = 16'($urandom);
      want = model(seed, 1'b0);
      expv = ($urandom_range(0, 1) == 1) ? want : want ^ 16'($urandom_range(1, 65535));
      send_frame(0, seed, expv, want, 2, 1'b0);
      idle($urandom_range(0, 2));
    end
    for (int f = 0; f < 40; f++) begin
      fb.delete();
      n = $urandom_range(0, 24);
      repeat (n) fb.push_back(8'($urandom));
      seed = 16'($urandom);
      want = model(seed, 1'b1);
      expv = ($urandom_range(0, 1) == 1) ? want : want ^ 16'($urandom_range(1, 65535));
      send_frame(1, seed, expv, want, 2, 1'b0);
      idle($urandom_range(0, 2));
    end

    // Every booked result must have appeared
    drain();
    check("a_pending", 32'(exp_q_a.size()), 32'd0);
    check("b_pending", 32'(exp_q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
